// File: rtl/result_stream_arbiter.sv
// result_stream_arbiter
// Shares one 8-bit result link among NUM_SOURCES decoder controllers.
// Whole frames are granted in round-robin order, so payload bytes from
// different sources never interleave. Each frame on the link is one header
// byte {HEADER_TAG, source index} followed by FRAME_BYTES payload bytes.
//
// Optional build macro: RESULT_ARB_CHECKSUM_EN
//   When defined, each frame also ends with a trailer byte holding the XOR of
//   its payload bytes, so a frame is FRAME_BYTES+2 bytes on the link.
//   When undefined, a frame is FRAME_BYTES+1 bytes and there is no trailer.
//
// Reset is asynchronous and active-high. It aborts any frame in progress
// immediately; the host resynchronises on the next header tag.

module result_stream_arbiter #(
  parameter int         NUM_SOURCES = 4,
  parameter int         FRAME_BYTES = 16,
  parameter logic [3:0] HEADER_TAG  = 4'hA,
  localparam int        SRC_W       = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_SOURCES*8-1:0] in_data,
  input  logic [NUM_SOURCES-1:0]   in_valid,
  output logic [NUM_SOURCES-1:0]   in_ready,
  output logic [7:0]               output_data,
  output logic                     output_valid,
  input  logic                     output_ready,
  output logic [SRC_W-1:0]         grant_id,
  output logic                     busy
);

`ifdef RESULT_ARB_CHECKSUM_EN
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HEADER  = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_TRAILER = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HEADER  = 2'd1,
    ST_PAYLOAD = 2'd2
  } state_t;
`endif

  // Registered state
  state_t           state_reg;
  logic [SRC_W-1:0] grant_reg;
  logic [SRC_W-1:0] rr_ptr_reg;
  logic [15:0]      byte_cnt_reg;
`ifdef RESULT_ARB_CHECKSUM_EN
  logic [7:0]       chk_reg;
`endif

  // Combinational helpers
  logic [7:0]       src_byte [NUM_SOURCES];
  logic             arb_found;
  logic [SRC_W-1:0] arb_idx;
  logic [SRC_W-1:0] arb_try;
  int               arb_scan;
  logic [SRC_W-1:0] ptr_after;
  logic             pay_hs;
  logic             last_byte;
  logic [7:0]       pay_byte;
  logic [3:0]       hdr_id;

  // Split the flat input bus into one byte per source.
  generate
    for (genvar gi = 0; gi < NUM_SOURCES; gi++) begin : g_src_byte
      assign src_byte[gi] = in_data[gi*8 +: 8];
    end
  endgenerate

  // Round-robin search: first requesting source at or after rr_ptr, wrapping.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    arb_try   = '0;
    arb_scan  = 0;
    for (int i = 0; i < NUM_SOURCES; i++) begin
      arb_scan = (int'(rr_ptr_reg) + i) % NUM_SOURCES;
      arb_try  = SRC_W'(arb_scan);
      if (!arb_found && in_valid[arb_try]) begin
        arb_found = 1'b1;
        arb_idx   = arb_try;
      end
    end
  end

  // Pointer value after the granted source finishes; with one source it stays 0.
  always_comb begin
    if (int'(grant_reg) >= NUM_SOURCES - 1) begin
      ptr_after = '0;
    end else begin
      ptr_after = grant_reg + 1'b1;
    end
  end

  assign pay_byte  = src_byte[grant_reg];
  assign pay_hs    = (state_reg == ST_PAYLOAD) && in_valid[grant_reg] && output_ready;
  assign last_byte = (byte_cnt_reg == 16'(FRAME_BYTES - 1));
  assign hdr_id    = 4'(grant_reg);

  // Frame sequencer: arbitrate in IDLE, then header, payload (and trailer).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      grant_reg    <= '0;
      rr_ptr_reg   <= '0;
      byte_cnt_reg <= '0;
`ifdef RESULT_ARB_CHECKSUM_EN
      chk_reg      <= '0;
`endif
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (arb_found) begin
            grant_reg <= arb_idx;
            state_reg <= ST_HEADER;
`ifdef RESULT_ARB_CHECKSUM_EN
            chk_reg   <= '0;
`endif
          end
        end

        ST_HEADER: begin
          // The header goes out even if the granted source dropped valid.
          if (output_ready) begin
            state_reg    <= ST_PAYLOAD;
            byte_cnt_reg <= '0;
          end
        end

        ST_PAYLOAD: begin
          if (pay_hs) begin
`ifdef RESULT_ARB_CHECKSUM_EN
            chk_reg <= chk_reg ^ pay_byte;
`endif
            if (last_byte) begin
              byte_cnt_reg <= '0;
`ifdef RESULT_ARB_CHECKSUM_EN
              state_reg    <= ST_TRAILER;
`else
              rr_ptr_reg   <= ptr_after;
              state_reg    <= ST_IDLE;
`endif
            end else begin
              byte_cnt_reg <= byte_cnt_reg + 16'd1;
            end
          end
        end

`ifdef RESULT_ARB_CHECKSUM_EN
        ST_TRAILER: begin
          if (output_ready) begin
            rr_ptr_reg <= ptr_after;
            state_reg  <= ST_IDLE;
          end
        end
`endif

        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  // Link output mux: header from registers, payload passed straight through.
  always_comb begin
    output_data  = 8'h00;
    output_valid = 1'b0;
    case (state_reg)
      ST_HEADER: begin
        output_data  = {HEADER_TAG, hdr_id};
        output_valid = 1'b1;
      end
      ST_PAYLOAD: begin
        output_data  = pay_byte;
        output_valid = in_valid[grant_reg];
      end
`ifdef RESULT_ARB_CHECKSUM_EN
      ST_TRAILER: begin
        output_data  = chk_reg;
        output_valid = 1'b1;
      end
`endif
      default: begin
        output_data  = 8'h00;
        output_valid = 1'b0;
      end
    endcase
  end

  // Only the granted source sees link readiness, and only during payload.
  generate
    for (genvar gi = 0; gi < NUM_SOURCES; gi++) begin : g_in_ready
      assign in_ready[gi] = (state_reg == ST_PAYLOAD) &&
                            (grant_reg == SRC_W'(gi)) &&
                            output_ready;
    end
  endgenerate

  assign grant_id = grant_reg;
  assign busy     = (state_reg != ST_IDLE);

endmodule
